// File: rtl/bus_pkg.sv
// Shared definitions for the system_bus master port and its arbiter:
// rd/wr control codes, arbiter state encoding and access-owner encoding.
package bus_pkg;

  // Load types on bus_rd_ctrl (0 = no read)
  localparam logic [2:0] CTRL_NONE = 3'd0;
  localparam logic [2:0] RD_LB     = 3'd1;
  localparam logic [2:0] RD_LH     = 3'd2;
  localparam logic [2:0] RD_LW     = 3'd3;
  localparam logic [2:0] RD_LD     = 3'd4;
  localparam logic [2:0] RD_LBU    = 3'd5;
  localparam logic [2:0] RD_LHU    = 3'd6;
  localparam logic [2:0] RD_LWU    = 3'd7;

  // Store types on bus_wr_ctrl (0 = no write)
  localparam logic [2:0] WR_SB     = 3'd1;
  localparam logic [2:0] WR_SH     = 3'd2;
  localparam logic [2:0] WR_SW     = 3'd3;
  localparam logic [2:0] WR_SD     = 3'd4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;

endpackage

// File: rtl/arb_priority.sv
// Combinational grant selection between IF and MEM.
// MEM wins by default; IF is forced once it has waited through STARVE_MAX
// consecutive MEM grants.
//   i_if_req / i_mem_req : qualified requests
//   i_starve_cnt         : MEM grants made while IF was waiting
//   o_gnt_if / o_gnt_mem : one-hot (or zero) grant
module arb_priority #(
  parameter int STARVE_MAX = 4
) (
  input  logic       i_if_req,
  input  logic       i_mem_req,
  input  logic [3:0] i_starve_cnt,
  output logic       o_gnt_if,
  output logic       o_gnt_mem
);

  logic w_force_if;

  assign w_force_if = i_if_req && (i_starve_cnt == 4'(STARVE_MAX));
  assign o_gnt_if   = i_if_req && (w_force_if || !i_mem_req);
  assign o_gnt_mem  = i_mem_req && !w_force_if;

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single system_bus master port between the instruction-fetch
// (IF) and memory-access (MEM) stages.
//   IF side  : if_req/if_addr/if_flush in, if_ready/if_rdata out
//   MEM side : mem_req/addr/rd_ctrl/wr_ctrl/wdata in, mem_ready/mem_rdata out
//   Bus side : bus_addr/rd_ctrl/wr_ctrl/din out, bus_dout in
//   busy     : arbiter not in IDLE
// Requests are sampled only in IDLE; the bus is driven only in ACCESS and
// the owner's ready pulses in DONE, which always returns to IDLE.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int         BUS_LAT    = 1,
  parameter int         STARVE_MAX = 4,
  parameter logic [2:0] IF_RD_CTRL = RD_LWU
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic [2:0]  mem_rd_ctrl,
  input  logic [2:0]  mem_wr_ctrl,
  input  logic [63:0] mem_wdata,
  output logic        mem_ready,
  output logic [63:0] mem_rdata,
  output logic [63:0] bus_addr,
  output logic [2:0]  bus_rd_ctrl,
  output logic [2:0]  bus_wr_ctrl,
  output logic [63:0] bus_din,
  input  logic [63:0] bus_dout,
  output logic        busy
);

  state_e      r_state, w_next;
  owner_e      r_owner;
  logic [63:0] r_addr, r_wdata;
  logic [2:0]  r_rd, r_wr;
  logic [2:0]  r_lat;
  logic [3:0]  r_starve;
  logic        r_flush;
  logic [31:0] r_if_rdata;
  logic [63:0] r_mem_rdata;

  logic w_mem_v, w_if_v, w_gnt_if, w_gnt_mem, w_last;

  assign w_mem_v = mem_req && ((mem_rd_ctrl | mem_wr_ctrl) != 3'd0);
  assign w_if_v  = if_req && !if_flush;
  assign w_last  = (r_lat == 3'd0);

  arb_priority #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .i_if_req     (w_if_v),
    .i_mem_req    (w_mem_v),
    .i_starve_cnt (r_starve),
    .o_gnt_if     (w_gnt_if),
    .o_gnt_mem    (w_gnt_mem)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    bus_addr    = '0;
    bus_rd_ctrl = CTRL_NONE;
    bus_wr_ctrl = CTRL_NONE;
    bus_din     = '0;
    if_ready    = 1'b0;
    mem_ready   = 1'b0;
    case (r_state)
      IDLE:   if (w_gnt_if || w_gnt_mem) w_next = ACCESS;
      ACCESS: begin
        bus_addr    = r_addr;
        bus_rd_ctrl = r_rd;
        bus_wr_ctrl = r_wr;
        bus_din     = r_wdata;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        // A flush arriving in DONE itself must also suppress the pulse.
        if_ready  = (r_owner == OWN_IF) && !r_flush && !if_flush;
        mem_ready = (r_owner == OWN_MEM);
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_IF;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= CTRL_NONE;
      r_wr        <= CTRL_NONE;
      r_lat       <= '0;
      r_starve    <= '0;
      r_flush     <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_flush <= 1'b0;
          if (w_gnt_if) begin
            r_owner  <= OWN_IF;
            r_addr   <= if_addr;
            r_rd     <= IF_RD_CTRL;
            r_wr     <= CTRL_NONE;
            r_wdata  <= '0;
            r_lat    <= 3'(BUS_LAT);
            r_starve <= '0;
          end else if (w_gnt_mem) begin
            r_owner <= OWN_MEM;
            r_addr  <= mem_addr;
            r_wr    <= mem_wr_ctrl;
            r_wdata <= mem_wdata;
            // Any write field wins: a mixed request is a pure store.
            r_rd    <= (mem_wr_ctrl != CTRL_NONE) ? CTRL_NONE : mem_rd_ctrl;
            r_lat   <= (mem_wr_ctrl != CTRL_NONE) ? 3'd0 : 3'(BUS_LAT);
            if (w_if_v && r_starve != 4'(STARVE_MAX))
              r_starve <= r_starve + 4'd1;
          end
        end
        ACCESS: begin
          if (if_flush && r_owner == OWN_IF) r_flush <= 1'b1;
          if (!w_last) begin
            r_lat <= r_lat - 3'd1;
          end else if (r_owner == OWN_IF) begin
            r_if_rdata <= bus_dout[31:0];
          end else begin
            r_mem_rdata <= (r_rd != CTRL_NONE) ? bus_dout : 64'd0;
          end
        end
        DONE: if (if_flush && r_owner == OWN_IF) r_flush <= 1'b1;
        default: ;
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_ready, mem_req, mem_ready, busy;
  logic [63:0] if_addr, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] if_rdata;
  logic [2:0]  mem_rd_ctrl, mem_wr_ctrl, bus_rd_ctrl, bus_wr_ctrl;
  logic [63:0] bus_addr, bus_din, bus_dout;

  bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rd_ctrl(mem_rd_ctrl),
    .mem_wr_ctrl(mem_wr_ctrl), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_addr(bus_addr), .bus_rd_ctrl(bus_rd_ctrl), .bus_wr_ctrl(bus_wr_ctrl),
    .bus_din(bus_din), .bus_dout(bus_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_if;
    logic [63:0] data;
    int          at;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_if, input logic [63:0] data, input int at);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    e.at    = at;
    q.push_back(e);
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst && (if_ready || mem_ready)) begin
      exp_t e;
      logic [63:0] act;
      n_vec++;
      act = if_ready ? {32'd0, if_rdata} : mem_rdata;
      if (if_ready && mem_ready) begin
        n_err++;
        $display("FAIL both_ready: if_ready and mem_ready both 1 at cycle %0d", cyc);
      end else if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: if=%0b mem=%0b data %h at cycle %0d, none expected",
                 if_ready, mem_ready, act, cyc);
      end else begin
        e = q.pop_front();
        if (e.is_if != if_ready || e.data !== act || e.at != cyc) begin
          n_err++;
          $display("FAIL ready: got if=%0b data %h cycle %0d expected if=%0b data %h cycle %0d",
                   if_ready, act, cyc, e.is_if, e.data, e.at);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_addr = 0; mem_rd_ctrl = 0; mem_wr_ctrl = 0; mem_wdata = 0;
    bus_dout = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ctrl", {52'd0, busy, if_ready, mem_ready, bus_rd_ctrl, bus_wr_ctrl}, 64'd0);
    chk("reset_data", bus_addr | bus_din | mem_rdata | {32'd0, if_rdata}, 64'd0);
    tick(); rst = 1'b0;
    tick();

    // MEM load: ready and data at cycle k+3
    k = cyc;
    mem_req = 1; mem_rd_ctrl = RD_LD; mem_addr = 64'h80; bus_dout = 64'hDEAD_BEEF_0123_4567;
    push(0, 64'hDEAD_BEEF_0123_4567, k + 3);
    tick(); @(negedge clk);
    chk("ld_rd_c1", {61'd0, bus_rd_ctrl}, {61'd0, RD_LD});
    chk("ld_addr_c1", bus_addr, 64'h80);
    tick(); @(negedge clk);
    chk("ld_rd_c2", {61'd0, bus_rd_ctrl}, {61'd0, RD_LD});
    tick(); @(negedge clk);
    chk("ld_done_bus", {58'd0, bus_rd_ctrl, bus_wr_ctrl}, 64'd0);
    tick(); mem_req = 0; mem_rd_ctrl = 0;
    tick();

    // Simultaneous: MEM store first, IF after one idle cycle
    k = cyc;
    if_req = 1; if_addr = 64'h1000;
    mem_req = 1; mem_wr_ctrl = WR_SD; mem_addr = 64'h2000; mem_wdata = 64'h55;
    bus_dout = 64'h0000_0000_1357_9BDF;
    push(0, 64'd0, k + 2);
    push(1, 64'h1357_9BDF, k + 6);
    tick(); @(negedge clk);
    chk("st_wr", {61'd0, bus_wr_ctrl}, {61'd0, WR_SD});
    chk("st_din", bus_din, 64'h55);
    chk("st_addr", bus_addr, 64'h2000);
    tick();
    tick(); mem_req = 0; mem_wr_ctrl = 0;
    tick(); @(negedge clk);
    chk("if_addr", bus_addr, 64'h1000);
    chk("if_rdctl", {58'd0, bus_rd_ctrl, bus_wr_ctrl}, {58'd0, RD_LWU, 3'd0});
    tick(); tick();
    tick(); if_req = 0;
    tick();

    // Starvation: IF granted on the 5th grant, after 4 MEM loads
    k = cyc;
    if_req = 1; if_addr = 64'h3000;
    mem_req = 1; mem_rd_ctrl = RD_LD; mem_addr = 64'h100;
    bus_dout = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 4; i++) push(0, 64'h1111_2222_3333_4444, k + 3 + 4 * i);
    push(1, 64'h3333_4444, k + 19);
    repeat (17) tick();
    mem_req = 0; mem_rd_ctrl = 0;
    repeat (3) tick();
    if_req = 0;
    tick();

    // Counter cleared: MEM again wins; mixed rd+wr acts as a store
    k = cyc;
    if_req = 1; if_addr = 64'h1000;
    mem_req = 1; mem_wr_ctrl = WR_SW; mem_rd_ctrl = RD_LW; mem_addr = 64'h2008; mem_wdata = 64'hAA;
    bus_dout = 64'h0000_0000_2468_ACE0;
    push(0, 64'd0, k + 2);
    push(1, 64'h2468_ACE0, k + 6);
    tick(); @(negedge clk);
    chk("mix_ctrl", {58'd0, bus_rd_ctrl, bus_wr_ctrl}, {58'd0, 3'd0, WR_SW});
    tick();
    tick(); mem_req = 0; mem_wr_ctrl = 0; mem_rd_ctrl = 0;
    repeat (4) tick();
    if_req = 0;
    tick();

    // Flush during first ACCESS: access completes, no if_ready, retry served
    k = cyc;
    if_req = 1; if_addr = 64'h1004; bus_dout = 64'h0000_0000_CAFE_F00D;
    push(1, 64'hCAFE_F00D, k + 7);
    tick(); if_flush = 1;
    @(negedge clk);
    chk("fl_addr", bus_addr, 64'h1004);
    tick(); if_flush = 0; if_addr = 64'h2000;
    @(negedge clk);
    chk("fl_rd_c2", {61'd0, bus_rd_ctrl}, {61'd0, RD_LWU});
    tick(); @(negedge clk);
    chk("fl_no_ready", {63'd0, if_ready}, 64'd0);
    tick(); tick(); @(negedge clk);
    chk("fl_retry_addr", bus_addr, 64'h2000);
    tick(); tick();
    tick(); if_req = 0;
    tick();

    // Reset in the middle of a read
    k = cyc;
    mem_req = 1; mem_rd_ctrl = RD_LW; mem_addr = 64'h40;
    tick(); @(negedge clk);
    chk("rst_busy_before", {63'd0, busy}, 64'd1);
    tick(); rst = 1; mem_req = 0; mem_rd_ctrl = 0;
    tick(); @(negedge clk);
    chk("rst_mid_ctrl", {52'd0, busy, if_ready, mem_ready, bus_rd_ctrl, bus_wr_ctrl}, 64'd0);
    chk("rst_mid_bus", bus_addr | bus_din, 64'd0);
    tick(); rst = 0;
    tick();

    // Null MEM request: never granted
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      chk("null_req", {57'd0, busy, bus_rd_ctrl, bus_wr_ctrl}, 64'd0);
    end
    mem_req = 0;

    repeat (5) tick();
    chk("pending_resp", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
